// File: rtl/fme_arbitro_if.sv
// Handshake bundle between the fme arbiter and the requester / fme side.
// master: the arbiter itself. slave: the requesters plus the fme engine.
interface fme_arbitro_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] in_sel;
    logic                fme_enable;
    logic                fme_done;
    logic                fme_reset;
    logic                res_valid;
    logic [ID_WIDTH-1:0] res_id;
    logic                res_ready;
    logic                busy;
    logic                error;

    modport master (
        input  req, fme_done, res_ready,
        output grant, in_sel, fme_enable, fme_reset, res_valid, res_id, busy, error
    );

    modport slave (
        output req, fme_done, res_ready,
        input  grant, in_sel, fme_enable, fme_reset, res_valid, res_id, busy, error
    );
endinterface

// File: rtl/fme_arbitro.sv
// Round-robin arbiter / sequencer sharing one fme interpolation engine
// among NUM_REQ requesters, with a watchdog that aborts a hung engine.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | engine free, arbitrating among requesters
// S_START   | fme_enable pulse, watchdog cleared
// S_RUN     | waiting for fme_done, watchdog counting
// S_DELIVER | result held for owner until res_ready
// S_ABORT   | watchdog expired: fme_reset/error pulse, release engine
module fme_arbitro #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int TIMEOUT  = 1023,
    parameter int TO_WIDTH = 10
) (
    input  logic          clock,
    input  logic          reset,
    fme_arbitro_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DELIVER,
        S_ABORT
    } state_t;

    localparam int                  IDW1      = ID_WIDTH + 1;
    localparam logic [IDW1-1:0]     NUM_REQ_W = IDW1'(NUM_REQ);
    localparam logic [TO_WIDTH-1:0] TIMEOUT_W = TO_WIDTH'(TIMEOUT);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0] in_sel_q, in_sel_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic                fme_enable_q, fme_enable_d;
    logic                fme_reset_q, fme_reset_d;
    logic                res_valid_q, res_valid_d;
    logic [ID_WIDTH-1:0] res_id_q, res_id_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   first_hot;
    logic [ID_WIDTH-1:0]  offset;
    logic [IDW1-1:0]      sum;
    logic [IDW1-1:0]      sum_nxt;
    logic [ID_WIDTH-1:0]  winner;
    logic [ID_WIDTH-1:0]  winner_nxt;
    logic [TO_WIDTH-1:0]  wd_inc;

    assign wd_inc = wd_q + TO_WIDTH'(1);

    // Round-robin pick: rotate req so ptr sits at bit 0, isolate the lowest
    // set bit, then rotate the offset back (mod NUM_REQ, which need not be a
    // power of two).
    always_comb begin
        req_dbl   = {bus.req, bus.req} >> ptr_q;
        req_rot   = req_dbl[NUM_REQ-1:0];
        first_hot = req_rot & (~req_rot + NUM_REQ'(1));
        offset    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (first_hot == (NUM_REQ'(1) << i)) begin
                offset = ID_WIDTH'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        winner  = sum[ID_WIDTH-1:0];
        sum_nxt = {1'b0, winner} + IDW1'(1);
        if (sum_nxt >= NUM_REQ_W) begin
            sum_nxt = '0;
        end
        winner_nxt = sum_nxt[ID_WIDTH-1:0];
    end

    // Next-state logic; every output flop is derived from the next state so
    // all outputs leave the block registered.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        in_sel_d = in_sel_q;
        ptr_d    = ptr_q;
        wd_d     = wd_q;
        res_id_d = res_id_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d  = S_START;
                    grant_d  = NUM_REQ'(1) << winner;
                    in_sel_d = winner;
                    ptr_d    = winner_nxt;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_inc;
                // done has priority over a watchdog expiry in the same cycle
                if (bus.fme_done) begin
                    state_d  = S_DELIVER;
                    res_id_d = in_sel_q;
                end else if (wd_inc == TIMEOUT_W) begin
                    state_d = S_ABORT;
                end
            end
            S_DELIVER: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        fme_enable_d = (state_d == S_START);
        res_valid_d  = (state_d == S_DELIVER);
        fme_reset_d  = (state_d == S_ABORT);
        error_d      = (state_d == S_ABORT);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            in_sel_q     <= '0;
            ptr_q        <= '0;
            wd_q         <= '0;
            fme_enable_q <= 1'b0;
            fme_reset_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            in_sel_q     <= in_sel_d;
            ptr_q        <= ptr_d;
            wd_q         <= wd_d;
            fme_enable_q <= fme_enable_d;
            fme_reset_q  <= fme_reset_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.in_sel     = in_sel_q;
    assign bus.fme_enable = fme_enable_q;
    assign bus.fme_reset  = fme_reset_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_fme_arbitro.sv
// Self-checking bench for fme_arbitro: directed scenarios plus randomized
// transactions, compared against a transaction-level round-robin model.
module tb_fme_arbitro;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int TO  = 15;
    localparam int TOW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fme_arbitro_if #(.NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    fme_arbitro #(
        .NUM_REQ (NR),
        .ID_WIDTH(IW),
        .TIMEOUT (TO),
        .TO_WIDTH(TOW)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: first requester at or after the model pointer, wrapping.
    function automatic int model_pick(input logic [NR-1:0] r);
        int idx;
        for (int i = 0; i < NR; i++) begin
            idx = (m_ptr + i) % NR;
            if (r[idx[IW-1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},      bus.grant, 0);
        check({tag, "_in_sel"},     bus.in_sel, 0);
        check({tag, "_fme_enable"}, bus.fme_enable, 0);
        check({tag, "_fme_reset"},  bus.fme_reset, 0);
        check({tag, "_res_valid"},  bus.res_valid, 0);
        check({tag, "_res_id"},     bus.res_id, 0);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_error"},      bus.error, 0);
    endtask

    // One transaction: pat is the request level presented in an IDLE cycle,
    // d the RUN-cycle index (0-based) in which fme_done is raised (d >= TO
    // means never), r the number of extra DELIVER cycles with res_ready low.
    task automatic do_txn(input logic [NR-1:0] pat, input int d, input int r, input bit keep);
        int          w;
        logic [NR-1:0] g;
        bit          finished;
        check("idle_before_req", bus.busy, 0);
        bus.req = pat;
        w = model_pick(pat);
        g = NR'(1) << w;
        tick();
        check("grant", bus.grant, g);
        check("in_sel", bus.in_sel, w);
        check("fme_enable_pulse", bus.fme_enable, 1);
        check("busy_start", bus.busy, 1);
        m_ptr = (w + 1) % NR;
        if (!keep) bus.req = '0;
        bus.fme_done = 1'($urandom_range(0, 1));
        tick();
        finished = 1'b0;
        for (int k = 0; k < TO && !finished; k++) begin
            check("enable_once", bus.fme_enable, 0);
            check("grant_run", bus.grant, g);
            check("in_sel_run", bus.in_sel, w);
            check("no_early_error", bus.error, 0);
            check("no_early_valid", bus.res_valid, 0);
            bus.fme_done = (k == d);
            tick();
            if (k == d) begin
                finished = 1'b1;
                check("res_valid", bus.res_valid, 1);
                check("res_id", bus.res_id, w);
                check("no_error_deliver", bus.error, 0);
                check("grant_deliver", bus.grant, g);
                bus.fme_done  = 1'b0;
                bus.res_ready = (r == 0);
                for (int j = 0; j < r; j++) begin
                    bus.fme_done = 1'($urandom_range(0, 1));
                    tick();
                    check("bp_res_valid", bus.res_valid, 1);
                    check("bp_grant", bus.grant, g);
                    check("bp_in_sel", bus.in_sel, w);
                    check("bp_no_enable", bus.fme_enable, 0);
                end
                bus.fme_done  = 1'b0;
                bus.res_ready = 1'b1;
                tick();
                check("release_grant", bus.grant, 0);
                check("release_busy", bus.busy, 0);
                check("release_valid", bus.res_valid, 0);
                bus.res_ready = 1'b0;
            end else if (k == TO - 1) begin
                finished = 1'b1;
                check("abort_error", bus.error, 1);
                check("abort_fme_reset", bus.fme_reset, 1);
                check("abort_grant", bus.grant, g);
                check("abort_in_sel", bus.in_sel, w);
                check("abort_no_valid", bus.res_valid, 0);
                bus.fme_done = 1'b0;
                tick();
                check("abort_error_single", bus.error, 0);
                check("abort_reset_single", bus.fme_reset, 0);
                check("abort_grant_clr", bus.grant, 0);
                check("abort_busy_clr", bus.busy, 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NR-1:0] pat;
        bus.req       = '0;
        bus.fme_done  = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_no_req_grant", bus.grant, 0);

        // Fairness with all requesters held high: order 0,1,2,3,0,1,2,3
        for (int t = 0; t < 8; t++) begin
            do_txn(4'b1111, 2, 0, 1'b1);
        end
        bus.req = '0;

        // Single requester, done 5 cycles after enable
        do_txn(4'b0100, 4, 0, 1'b0);
        // Backpressure for 10 cycles
        do_txn(4'b0010, 1, 10, 1'b0);
        // Watchdog abort, then normal service
        do_txn(4'b1000, 1000, 0, 1'b0);
        do_txn(4'b1000, 3, 2, 1'b0);
        // done in the same cycle the watchdog reaches TIMEOUT, then one later
        do_txn(4'b0001, TO - 1, 1, 1'b0);
        do_txn(4'b0001, TO, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            pat = NR'($urandom_range(1, (1 << NR) - 1));
            do_txn(pat, $urandom_range(0, TO + 3), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end
        bus.req = '0;
        tick();

        // Reset in the middle of RUN
        bus.req = 4'b0100;
        tick();
        check("mid_grant", bus.grant, 4'b0100);
        bus.req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        m_ptr = 0;
        tick();
        check("post_reset_no_error", bus.error, 0);
        check("post_reset_idle", bus.busy, 0);
        do_txn(4'b1010, 2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fme_arbitro.md
# fme_arbitro

Round-robin arbiter and sequencer that shares one `fme` interpolation instance among `NUM_REQ` requesters (e.g. parallel motion-estimation search units). It grants the engine to one requester at a time and steers that requester's 32-sample input bus through an external mux via `in_sel`. It starts the engine, waits for `done`, and holds the result for the owner until it is consumed. A watchdog recovers the engine if `done` never arrives. It sits between the search units and the `fme` top-level `enable`/`done`/`reset` pins.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `ID_WIDTH`, 2: width of requester index; must equal ceil(log2(NUM_REQ)).
- `TIMEOUT`, 1023: maximum cycles in RUN before abort.
- `TO_WIDTH`, 10: watchdog counter width; must hold `TIMEOUT`.
- `clock`  in  1  single clock domain; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level; held until its grant bit rises.
- `grant`  out  NUM_REQ  one-hot owner of the engine; zero when idle.
- `in_sel`  out  ID_WIDTH  index of owner; drives the external input-bus mux.
- `fme_enable`  out  1  single-cycle start pulse to `fme`.
- `fme_done`  in  1  `fme` completion level.
- `fme_reset`  out  1  engine clear pulse on watchdog abort; ORed with `reset` outside this block.
- `res_valid`  out  1  engine outputs are valid for owner `res_id`.
- `res_id`  out  ID_WIDTH  owner index accompanying `res_valid`.
- `res_ready`  in  1  owner has captured the `fme` outputs.
- `busy`  out  1  state not IDLE.
- `error`  out  1  single-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, RUN, DELIVER, ABORT.
- **IDLE**
  - If `req` is nonzero, pick the winner: the first set bit at or after `ptr`, searching upward with wrap-around (`ptr` is an ID_WIDTH register).
  - Register `grant` = one-hot(winner) and `in_sel` = winner, then go to START.
  - `req` bits equal to 0 are never granted.
  - `ptr` becomes winner+1 mod NUM_REQ at the grant edge.
- **START**: `fme_enable`=1 for exactly this cycle. Clear the watchdog counter. Go to RUN.
- **RUN**
  - The watchdog counter increments each cycle.
  - If `fme_done`=1, go to DELIVER.
  - Otherwise, if the counter equals `TIMEOUT`, go to ABORT.
  - If `fme_done` is asserted in the same cycle the counter reaches `TIMEOUT`, `done` wins.
- **DELIVER**
  - `res_valid`=1 and `res_id`=`in_sel`; `grant` and `in_sel` stay stable so the owner reads the held `fme` outputs.
  - On `res_valid && res_ready`, go to IDLE; `grant` clears at that edge.
- **ABORT**: `fme_reset`=1 and `error`=1 for this single cycle. `grant` is cleared. Go to IDLE. `ptr` has already advanced, so the failing requester does not monopolise the engine.
- Requester behaviour after grant:
  - Dropping `req` after grant does not cancel the transaction.
  - A requester that keeps `req` high after DELIVER is re-arbitrated normally.
- `fme_done` is ignored outside RUN.
- `in_sel` is stable from the START cycle through the last DELIVER/ABORT cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `grant`=0, `in_sel`=0, `fme_enable`=0, `fme_reset`=0, `res_valid`=0, `res_id`=0, `busy`=0, `error`=0, `ptr`=0, watchdog=0.
- Reset mid-transaction returns to IDLE on the next edge, with no `error` pulse and no `fme_reset` pulse (system reset clears `fme`).
- Latency: `req` high in IDLE cycle N gives `grant`/`busy` high in cycle N+1, with `fme_enable` pulsed in cycle N+1.
- Completion: `fme_done` high in RUN cycle M gives `res_valid` high in cycle M+1.
- Release: `res_ready` sampled high in cycle K gives `grant`=0 and `busy`=0 in cycle K+1. A new grant is possible in K+2 at the earliest, giving one idle cycle between transactions.
- Abort: with no `done`, `fme_reset`/`error` pulse in cycle N+2+TIMEOUT (where N+1 is the START cycle).
- Minimum transaction length: 4 cycles (START, RUN, DELIVER, IDLE).

## Test plan
- **Single requester:** `req`=4'b0100 with `fme_done` 5 cycles after `fme_enable` and `res_ready` held high gives the following.
  - `grant`=4'b0100 and `in_sel`=2 one cycle after `req`.
  - One `fme_enable` pulse.
  - `res_valid` with `res_id`=2 exactly one cycle after `done`.
  - `grant`=0 on the next cycle.
- **Round-robin fairness:** `req`=4'b1111 held constant for 8 transactions gives the grant order 0,1,2,3,0,1,2,3.
- **Backpressure:** `res_ready`=0 for 10 cycles in DELIVER gives `res_valid`, `grant` and `in_sel` stable for all 10 cycles, and no second `fme_enable`.
- **Watchdog:** `TIMEOUT`=15 and `fme_done` never asserted give a single `error`+`fme_reset` pulse 16 cycles after the START cycle, then `grant`=0. The next `req` is served normally.
- **Done/timeout tie:** `fme_done` rising in the same cycle the counter reaches `TIMEOUT` gives DELIVER with no `error`.
- **Reset mid-RUN:** asserting `reset` for 1 cycle during RUN returns all outputs to their reset values on the next edge with no `error`, and the next arbitration starts from `ptr`=0.
